// File: rtl/znd_seq_if.sv
// Host-side configuration and firing-table bundle for the znd_seq frame scheduler.
// The host or bench drives through master; the scheduler uses slave.
interface znd_seq_if;
  logic              run;
  logic              single;
  logic              ext_mode;
  logic              ext_trig;
  logic [23:0]       period;
  logic [23:0]       first_delay;
  logic [23:0]       spacing;
  logic [3:0]        ch_en;
  logic [7:0]        ch_order;
  logic              msync_n;
  logic [23:0]       znd_delay0;
  logic [23:0]       znd_delay1;
  logic [23:0]       znd_delay2;
  logic [23:0]       znd_delay3;
  logic [7:0]        num_order;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic              overrun;
  logic              cfg_err;

  modport master (
    output run, single, ext_mode, ext_trig, period, first_delay, spacing, ch_en, ch_order,
    input  msync_n, znd_delay0, znd_delay1, znd_delay2, znd_delay3, num_order,
           busy, frame_cnt, overrun, cfg_err
  );

  modport slave (
    input  run, single, ext_mode, ext_trig, period, first_delay, spacing, ch_en, ch_order,
    output msync_n, znd_delay0, znd_delay1, znd_delay2, znd_delay3, num_order,
           busy, frame_cnt, overrun, cfg_err
  );
endinterface

// File: rtl/znd_seq.sv
// Frame scheduler for the four-channel firing block: master sync generation and
// per-frame firing-table construction (compacted channel order, spaced match delays).
module znd_seq #(
  parameter int MIN_PERIOD  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic      clk20,
  input logic      res,
  znd_seq_if.slave zif
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_LOAD, S_CALC0, S_CALC1, S_CALC2, S_CALC3, S_FIRE, S_WAIT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_oneshot;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_trig_prev;
  logic                   w_trig_edge;
  logic                   w_abort;
  logic                   w_fire_edge;
  logic [23:0]            r_wcnt;

  logic [23:0]            r_sh_period;
  logic [23:0]            r_sh_spacing;
  logic [3:0]             r_sh_en;
  logic [7:0]             r_sh_order;

  logic [3:0]             r_used;
  logic [1:0]             r_n;
  logic [24:0]            r_acc;
  logic [3:0][23:0]       r_stg_dly;
  logic [7:0]             r_stg_ord;
  logic                   r_stg_err;

  logic [3:0]             w_used_nxt;
  logic [1:0]             w_n_nxt;
  logic [24:0]            w_acc_nxt;
  logic [3:0][23:0]       w_dly_nxt;
  logic [7:0]             w_ord_nxt;
  logic                   w_err_nxt;
  logic [1:0]             w_ch;
  logic                   w_calc;

  logic                   r_msync_n;
  logic [3:0][23:0]       r_dly_out;
  logic [7:0]             r_ord_out;
  logic                   r_err_out;
  logic [15:0]            r_frame_cnt;
  logic                   r_overrun;

  function automatic logic [23:0] clamp_dly(input logic [24:0] a);
    return (a >= 25'h0FFFFFF) ? 24'hFFFFFF : a[23:0];
  endfunction

  function automatic logic [24:0] sat_acc(input logic [24:0] a, input logic [23:0] b);
    logic [25:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[25] ? 25'h1FFFFFF : s[24:0];
  endfunction

  function automatic logic [23:0] floor_period(input logic [23:0] p);
    return (p < 24'(MIN_PERIOD)) ? 24'(MIN_PERIOD) : p;
  endfunction

  assign w_trig_edge = r_sync[SYNC_STAGES-1] & ~r_trig_prev;
  // A single-shot frame runs to completion even though run is low.
  assign w_abort     = ~zif.run & ~r_oneshot;
  assign w_fire_edge = (r_state == S_CALC3) && (w_state_nxt == S_FIRE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (zif.run)         w_state_nxt = zif.ext_mode ? S_ARM : S_LOAD;
        else if (zif.single) w_state_nxt = S_LOAD;
      end
      S_ARM: begin
        if (!zif.run)         w_state_nxt = S_IDLE;
        else if (w_trig_edge) w_state_nxt = S_LOAD;
      end
      S_LOAD:  w_state_nxt = w_abort ? S_IDLE : S_CALC0;
      S_CALC0: w_state_nxt = w_abort ? S_IDLE : S_CALC1;
      S_CALC1: w_state_nxt = w_abort ? S_IDLE : S_CALC2;
      S_CALC2: w_state_nxt = w_abort ? S_IDLE : S_CALC3;
      S_CALC3: w_state_nxt = w_abort ? S_IDLE : S_FIRE;
      S_FIRE: begin
        if (r_oneshot || !zif.run) w_state_nxt = S_IDLE;
        else if (zif.ext_mode)     w_state_nxt = S_ARM;
        else                       w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!zif.run)          w_state_nxt = S_IDLE;
        else if (r_wcnt == '0) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Table builder: one requested order slot examined per CALC cycle.
  always_comb begin
    w_used_nxt = r_used;
    w_n_nxt    = r_n;
    w_acc_nxt  = r_acc;
    w_dly_nxt  = r_stg_dly;
    w_ord_nxt  = r_stg_ord;
    w_err_nxt  = r_stg_err;
    w_ch       = 2'd0;
    w_calc     = 1'b1;
    case (r_state)
      S_CALC0: w_ch = r_sh_order[1:0];
      S_CALC1: w_ch = r_sh_order[3:2];
      S_CALC2: w_ch = r_sh_order[5:4];
      S_CALC3: w_ch = r_sh_order[7:6];
      default: w_calc = 1'b0;
    endcase
    if (w_calc && r_sh_en[w_ch] && !r_used[w_ch]) begin
      w_dly_nxt[r_n]              = clamp_dly(r_acc);
      w_err_nxt                   = r_stg_err | (r_acc >= 25'h0FFFFFF);
      w_ord_nxt[{r_n, 1'b0} +: 2] = w_ch;
      w_used_nxt[w_ch]            = 1'b1;
      w_n_nxt                     = r_n + 2'd1;
      w_acc_nxt                   = sat_acc(r_acc, r_sh_spacing);
    end
  end

  always_ff @(posedge clk20 or posedge res) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_oneshot   <= 1'b0;
      r_sync      <= '0;
      r_trig_prev <= 1'b0;
      r_wcnt      <= '0;
      r_used      <= '0;
      r_n         <= '0;
      r_acc       <= '0;
      r_msync_n   <= 1'b1;
      r_dly_out   <= {4{24'hFFFFFF}};
      r_ord_out   <= 8'hE4;
      r_err_out   <= 1'b0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sync      <= {r_sync[SYNC_STAGES-2:0], zif.ext_trig};
      r_trig_prev <= r_sync[SYNC_STAGES-1];

      if (r_state == S_IDLE && !zif.run && zif.single) r_oneshot <= 1'b1;
      else if (r_state == S_FIRE)                       r_oneshot <= 1'b0;

      // WAIT length makes the next FIRE land exactly P cycles after this one.
      if (r_state == S_FIRE)      r_wcnt <= floor_period(r_sh_period) - 24'd7;
      else if (r_state == S_WAIT) r_wcnt <= r_wcnt - 24'd1;

      if (r_state == S_LOAD) begin
        r_used <= '0;
        r_n    <= '0;
        r_acc  <= {1'b0, zif.first_delay};
      end else begin
        r_used <= w_used_nxt;
        r_n    <= w_n_nxt;
        r_acc  <= w_acc_nxt;
      end

      r_msync_n <= ~w_fire_edge;
      if (w_fire_edge) begin
        r_dly_out   <= w_dly_nxt;
        r_ord_out   <= w_ord_nxt;
        r_err_out   <= w_err_nxt;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      if (!zif.run) r_overrun <= 1'b0;
      else if (w_trig_edge && zif.ext_mode && r_state != S_ARM) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk20) begin
    if (r_state == S_LOAD) begin
      r_sh_period  <= zif.period;
      r_sh_spacing <= zif.spacing;
      r_sh_en      <= zif.ch_en;
      r_sh_order   <= zif.ch_order;
      r_stg_dly    <= {4{24'hFFFFFF}};
      r_stg_ord    <= 8'h00;
      r_stg_err    <= 1'b0;
    end else begin
      r_stg_dly    <= w_dly_nxt;
      r_stg_ord    <= w_ord_nxt;
      r_stg_err    <= w_err_nxt;
    end
  end

  assign zif.msync_n    = r_msync_n;
  assign zif.znd_delay0 = r_dly_out[0];
  assign zif.znd_delay1 = r_dly_out[1];
  assign zif.znd_delay2 = r_dly_out[2];
  assign zif.znd_delay3 = r_dly_out[3];
  assign zif.num_order  = r_ord_out;
  assign zif.busy       = (r_state != S_IDLE);
  assign zif.frame_cnt  = r_frame_cnt;
  assign zif.overrun    = r_overrun;
  assign zif.cfg_err    = r_err_out;

endmodule

// File: tb/tb_znd_seq.sv
// Randomized bench for znd_seq against a table/timing reference model.
module tb_znd_seq;
  logic clk;
  logic res;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [15:0] exp_fc = 16'd0;

  znd_seq_if zif();

  znd_seq #(.MIN_PERIOD(8), .SYNC_STAGES(2)) dut (
    .clk20 (clk),
    .res   (res),
    .zif   (zif)
  );

  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the requested order, keep first occurrence of each enabled channel.
  function automatic void ref_table(input logic [3:0] en, input logic [7:0] ord,
                                    input logic [23:0] fd, input logic [23:0] sp,
                                    output logic [3:0][23:0] d, output logic [7:0] o,
                                    output logic e);
    longint acc;
    int     n;
    int     c;
    bit [3:0] used;
    acc = fd; n = 0; used = 0; o = 0; e = 0;
    for (int k = 0; k < 4; k++) d[k] = 24'hFFFFFF;
    for (int i = 0; i < 4; i++) begin
      c = int'((ord >> (2 * i)) & 8'h03);
      if (en[c] && !used[c]) begin
        if (acc >= 64'hFFFFFF) begin
          d[n] = 24'hFFFFFF;
          e = 1;
        end else begin
          d[n] = 24'(acc);
        end
        o = o | 8'(c << (2 * n));
        used[c] = 1;
        n++;
        acc = acc + longint'(sp);
        if (acc > 64'h1FFFFFF) acc = 64'h1FFFFFF;
      end
    end
  endfunction

  task automatic chk_table(input logic [3:0][23:0] d, input logic [7:0] o, input logic e);
    chk("dly0", zif.znd_delay0, d[0]);
    chk("dly1", zif.znd_delay1, d[1]);
    chk("dly2", zif.znd_delay2, d[2]);
    chk("dly3", zif.znd_delay3, d[3]);
    chk("order", zif.num_order, o);
    chk("cfg_err", zif.cfg_err, e);
    chk("frame_cnt", zif.frame_cnt, exp_fc);
  endtask

  task automatic set_cfg(input logic [23:0] per, input logic [3:0] en, input logic [7:0] ord,
                         input logic [23:0] fd, input logic [23:0] sp);
    zif.period = per; zif.ch_en = en; zif.ch_order = ord;
    zif.first_delay = fd; zif.spacing = sp;
  endtask

  task automatic do_frames(input logic [23:0] per, input logic [3:0] en, input logic [7:0] ord,
                           input logic [23:0] fd, input logic [23:0] sp, input int nf);
    logic [3:0][23:0] ed;
    logic [7:0] eo;
    logic ee, low;
    int p, last;
    p = (int'(per) < 8) ? 8 : int'(per);
    ref_table(en, ord, fd, sp, ed, eo, ee);
    @(negedge clk);
    set_cfg(per, en, ord, fd, sp);
    zif.ext_mode = 1'b0;
    zif.run = 1'b1;
    last = 6 + p * (nf - 1);
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      low = (j >= 6) && (((j - 6) % p) == 0);
      chk("msync_free", zif.msync_n, !low);
      if (low) begin
        exp_fc++;
        chk_table(ed, eo, ee);
        chk("busy_fire", zif.busy, 1'b1);
      end
    end
    zif.run = 1'b0;
    @(negedge clk);
    chk("busy_stop", zif.busy, 1'b0);
    chk("msync_stop", zif.msync_n, 1'b1);
    chk("hold_dly0", zif.znd_delay0, ed[0]);
  endtask

  task automatic ext_frame(input logic [3:0] en, input logic [7:0] ord, input logic [23:0] fd,
                           input logic [23:0] sp, input bit second);
    logic [3:0][23:0] ed;
    logic [7:0] eo;
    logic ee;
    ref_table(en, ord, fd, sp, ed, eo, ee);
    @(negedge clk);
    set_cfg(24'd20, en, ord, fd, sp);
    zif.ext_mode = 1'b1;
    zif.run = 1'b1;
    for (int j = 0; j < 4; j++) @(negedge clk);
    chk("arm_busy", zif.busy, 1'b1);
    chk("arm_msync", zif.msync_n, 1'b1);
    zif.ext_trig = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      if (j == 3) zif.ext_trig = 1'b0;
      if (second && j == 4) zif.ext_trig = 1'b1;
      if (j == 6) zif.ext_trig = 1'b0;
      chk("msync_ext", zif.msync_n, j != 8);
      if (j == 8) begin
        exp_fc++;
        chk_table(ed, eo, ee);
      end
    end
    chk("overrun", zif.overrun, second);
    zif.run = 1'b0;
    @(negedge clk);
    chk("overrun_clr", zif.overrun, 1'b0);
    chk("ext_idle", zif.busy, 1'b0);
    zif.ext_mode = 1'b0;
  endtask

  task automatic single_frame(input logic [3:0] en, input logic [7:0] ord, input logic [23:0] fd,
                              input logic [23:0] sp);
    logic [3:0][23:0] ed;
    logic [7:0] eo;
    logic ee;
    ref_table(en, ord, fd, sp, ed, eo, ee);
    @(negedge clk);
    set_cfg(24'd3, en, ord, fd, sp);
    zif.run = 1'b0;
    zif.single = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      zif.single = 1'b0;
      chk("msync_single", zif.msync_n, j != 6);
      chk("busy_single", zif.busy, j <= 6);
      if (j == 6) begin
        exp_fc++;
        chk_table(ed, eo, ee);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_msync"}, zif.msync_n, 1'b1);
    chk({tag, "_dly0"}, zif.znd_delay0, 24'hFFFFFF);
    chk({tag, "_dly1"}, zif.znd_delay1, 24'hFFFFFF);
    chk({tag, "_dly2"}, zif.znd_delay2, 24'hFFFFFF);
    chk({tag, "_dly3"}, zif.znd_delay3, 24'hFFFFFF);
    chk({tag, "_order"}, zif.num_order, 8'hE4);
    chk({tag, "_busy"}, zif.busy, 1'b0);
    chk({tag, "_fc"}, zif.frame_cnt, 16'd0);
    chk({tag, "_ovr"}, zif.overrun, 1'b0);
    chk({tag, "_err"}, zif.cfg_err, 1'b0);
  endtask

  initial begin
    logic [23:0] per, fd, sp;
    logic [3:0]  en;
    logic [7:0]  ord;
    res = 1'b1;
    zif.run = 1'b0; zif.single = 1'b0; zif.ext_mode = 1'b0; zif.ext_trig = 1'b0;
    set_cfg(24'd0, 4'h0, 8'h00, 24'd0, 24'd0);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    res = 1'b0;
    @(negedge clk);

    do_frames(24'd20, 4'hF, 8'hE4, 24'd100, 24'd50, 3);
    do_frames(24'd20, 4'b1010, 8'h1B, 24'd100, 24'd50, 2);
    do_frames(24'd20, 4'b0001, 8'h00, 24'd100, 24'd50, 2);
    do_frames(24'd20, 4'hF, 8'hE4, 24'hFFFFF0, 24'd16, 2);
    do_frames(24'd3, 4'hF, 8'hE4, 24'd10, 24'd5, 3);

    for (int t = 0; t < 12; t++) begin
      per = 24'($urandom_range(0, 40));
      en  = 4'($urandom);
      ord = 8'($urandom);
      if ($urandom_range(0, 1) == 1) fd = 24'($urandom_range(0, 2000));
      else fd = 24'hFFFFFF - 24'($urandom_range(0, 400));
      if ($urandom_range(0, 1) == 1) sp = 24'($urandom_range(0, 300));
      else sp = 24'($urandom);
      do_frames(per, en, ord, fd, sp, int'($urandom_range(2, 3)));
    end

    ext_frame(4'hF, 8'hE4, 24'd100, 24'd50, 1'b0);
    ext_frame(4'($urandom), 8'($urandom), 24'($urandom_range(0, 5000)), 24'($urandom_range(0, 500)), 1'b1);

    single_frame(4'b0110, 8'h9C, 24'd7, 24'd3);

    // Reset asserted while the scheduler is in CALC2.
    @(negedge clk);
    set_cfg(24'd20, 4'hF, 8'hE4, 24'd300, 24'd10);
    zif.run = 1'b1;
    for (int j = 1; j <= 4; j++) @(negedge clk);
    res = 1'b1;
    zif.run = 1'b0;
    #1;
    chk_reset_vals("midrst");
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("midrst_msync", zif.msync_n, 1'b1);
    end
    res = 1'b0;
    exp_fc = 16'd0;
    @(negedge clk);
    chk("post_rst_fc", zif.frame_cnt, exp_fc);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/znd_seq.md
Name: znd_seq

Overview:
- Frame scheduler and configurator for the four-channel probe firing block.
- Generates the master sync pulse (msync_n), either free-running from a period counter or on an external trigger.
- Builds the per-frame firing table from an enable mask, a requested channel order, a first delay and an inter-channel spacing. The table is the four 24-bit match delays plus the 2-bit-per-slot order word.
- Sits between the host register file and the firing block. All logic is in the clk20 domain.

Parameters:
- MIN_PERIOD, 8: minimum free-run period in clk20 cycles; smaller period values are raised to this.
- SYNC_STAGES, 2: synchroniser depth for ext_trig.

Ports:
- clk20  in  1  system clock (20 MHz)
- res  in  1  asynchronous reset, active-high
- run  in  1  level; enables scheduling
- single  in  1  one-cycle pulse; fires exactly one frame when run=0 and the FSM is in IDLE
- ext_mode  in  1  0 = free-run, 1 = external trigger
- ext_trig  in  1  asynchronous trigger; rising edge starts a frame
- period  in  24  free-run msync_n spacing in cycles
- first_delay  in  24  delay of first enabled channel after msync_n
- spacing  in  24  delay increment between consecutive enabled channels
- ch_en  in  4  per-channel enable
- ch_order  in  8  requested order; slot i = ch_order[2i+1:2i]
- msync_n  out  1  master sync, active-low, one cycle wide
- znd_delay0..znd_delay3  out  24 each  match delays, slot 0..3
- num_order  out  8  channel number per firing slot
- busy  out  1  high in every state except IDLE
- frame_cnt  out  16  frames fired, wraps
- overrun  out  1  sticky: trigger lost
- cfg_err  out  1  last computed table had a clamped delay

Behaviour:
- Reset values:
  - msync_n=1.
  - All znd_delayN=24'hFFFFFF. A delay of 24'hFFFFFF never fires downstream.
  - num_order=8'hE4.
  - busy=0, frame_cnt=0, overrun=0, cfg_err=0.
  - FSM in IDLE; internal counters and synchroniser cleared.
- FSM states: IDLE, ARM, LOAD, CALC0..CALC3, FIRE, WAIT.
- IDLE:
  - run=1 -> LOAD.
  - single=1 (run=0) -> LOAD with a one-shot flag set.
- LOAD (1 cycle):
  - Snapshot all config inputs into shadow registers.
  - Clear the used mask and the slot index n.
  - Set accumulator acc = first_delay (25 bits).
  - Input changes after LOAD do not affect the current frame.
- CALCi (1 cycle each, i=0..3):
  - Let c = shadow ch_order[2i+1:2i].
  - If ch_en[c]=1 and used[c]=0:
    - staged delay[n] = acc, clamped to 24'hFFFFFF if acc >= 24'hFFFFFF; a clamp sets staged err.
    - staged order slot n = c.
    - used[c]=1; n++; acc += spacing, saturating at 25'h1FFFFFF.
  - Duplicate channels in ch_order and disabled channels are skipped.
  - Unfilled slots get delay 24'hFFFFFF and order 2'b00.
- FIRE (1 cycle):
  - msync_n=0.
  - Staged table and err are copied to the outputs on the same edge msync_n falls.
  - Outputs then hold until the next FIRE.
  - frame_cnt increments.
- After FIRE:
  - One-shot flag set -> IDLE (flag cleared).
  - ext_mode=1 -> ARM.
  - Otherwise -> WAIT.
- Free-run timing:
  - P = max(period, MIN_PERIOD).
  - Successive msync_n low cycles are exactly P cycles apart.
  - WAIT counts, then enters LOAD so that FIRE lands on cycle P.
  - First msync_n low occurs 6 cycles after the edge that samples run=1 in IDLE (LOAD, CALC0..3, FIRE).
- External trigger:
  - ext_trig passes through SYNC_STAGES flops, then a rising-edge detector.
  - A detected edge in ARM -> LOAD.
  - msync_n is low in the 8th cycle after the first clk20 edge sampling ext_trig=1 (SYNC_STAGES=2).
  - Initial entry with ext_mode=1 goes IDLE -> ARM first, not LOAD.
- overrun:
  - Set when an edge is detected while in any state other than ARM with ext_mode=1 and run=1.
  - That trigger is dropped.
  - Cleared only by reset or by run falling.
- run falling:
  - Returns to IDLE from any state at the next edge.
  - If the current state is FIRE, FIRE completes first.
  - Outputs keep their last values; msync_n=1.
- ext_mode changes take effect at the next LOAD-to-FIRE boundary decision, i.e. the FIRE exit.
- Asynchronous reset mid-frame immediately forces all reset values; no partial table reaches the outputs.

Test Plan:
- Free-run: run=1, ext_mode=0, period=20, ch_en=4'hF, ch_order=8'hE4, first_delay=100, spacing=50 -> msync_n low 6 cycles after run, then every 20 cycles; delays 100/150/200/250; num_order=8'hE4; frame_cnt increments each pulse.
- Compaction: ch_en=4'b1010, ch_order=8'h1B (3,2,1,0) -> num_order=8'h07 (slot0=3, slot1=1, others 0); delays 100/150/FFFFFF/FFFFFF; duplicate order 8'h00 with ch_en=1 -> single channel 0 at 100, rest FFFFFF.
- Clamp: first_delay=24'hFFFFF0, spacing=16, all enabled -> delay0=FFFFF0, delays1..3=FFFFFF, cfg_err=1 coincident with msync_n low.
- External trigger: ext_mode=1, pulse ext_trig high 3 cycles -> single msync_n low on 8th cycle; second edge during CALC -> no extra pulse, overrun=1 until run drops.
- Period floor and single: period=3 -> pulses 8 apart; run=0, single pulse -> exactly one msync_n, busy falls after FIRE.
- Reset mid-CALC: assert res during CALC2 -> outputs immediately at reset values, msync_n stays 1, frame_cnt=0.
